// File: rtl/pmips_core_p.sv
// Parametrised 5-stage pipelined core for the 16-bit-instruction PMIPS subset.
// EX-stage forwarding, load-use interlock, branch resolution in EX with flush, retired-instruction counter.
module pmips_core_p #(
  parameter int DATA_W     = 16,
  parameter int FORWARD_EN = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic [DATA_W-1:0] imemaddr,
  input  logic [15:0]       imemrdata,
  output logic [DATA_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemwdata,
  output logic              dmemwrite,
  output logic              dmemread,
  input  logic [DATA_W-1:0] dmemrdata,
  output logic [DATA_W-1:0] aluresult,
  output logic              stall,
  output logic              flush,
  output logic [CNT_W-1:0]  instret
);

  localparam logic FWD = (FORWARD_EN != 0);
  localparam logic [2:0] OP_R = 3'd0, OP_LW = 3'd1, OP_SW = 3'd2, OP_BEQ = 3'd3, OP_ADDI = 3'd4;

  typedef struct packed {
    logic       rw;
    logic       mr;
    logic       mw;
    logic       br;
    logic       imm;
    logic [2:0] alu;
    logic [2:0] dest;
  } ctrl_t;

  // rw is only ever set together with a nonzero dest, so hazard logic can skip dest!=0.
  function automatic ctrl_t decode(input logic [15:0] ins);
    ctrl_t c;
    c = '0;
    case (ins[15:13])
      OP_R:    if (ins[3:0] <= 4'd4) begin c.rw = 1'b1; c.alu = ins[2:0]; c.dest = ins[6:4]; end
      OP_LW:   begin c.rw = 1'b1; c.mr = 1'b1; c.imm = 1'b1; c.dest = ins[9:7]; end
      OP_SW:   begin c.mw = 1'b1; c.imm = 1'b1; end
      OP_BEQ:  c.br = 1'b1;
      OP_ADDI: begin c.rw = 1'b1; c.imm = 1'b1; c.dest = ins[9:7]; end
      default: ;
    endcase
    if (c.dest == 3'd0) c.rw = 1'b0;
    return c;
  endfunction

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [15:0]       ifid_ins_q;
  logic [DATA_W-1:0] ifid_pc_q;
  ctrl_t             idex_c_q;
  logic [DATA_W-1:0] idex_pc_q, idex_a_q, idex_b_q, idex_imm_q;
  logic [2:0]        idex_rs_q, idex_rt_q;
  logic              exmem_rw_q, exmem_mr_q, exmem_mw_q;
  logic [2:0]        exmem_dest_q;
  logic [DATA_W-1:0] exmem_alu_q, exmem_sd_q;
  logic              memwb_rw_q;
  logic [2:0]        memwb_dest_q;
  logic [DATA_W-1:0] memwb_data_q;
  logic [2:0]        vld_pipe_q;  // non-bubble flags for ID/EX, EX/MEM, MEM/WB
  logic [DATA_W-1:0] rf_q [8];
  logic [CNT_W-1:0]  instret_q;

  logic [2:0]        id_rs, id_rt;
  logic              id_rd_rs, id_rd_rt;
  ctrl_t             id_c;
  logic [DATA_W-1:0] id_imm, id_a, id_b;
  logic [DATA_W-1:0] ex_a, ex_b, ex_op2, ex_res, ex_tgt;

  assign id_rs  = ifid_ins_q[12:10];
  assign id_rt  = ifid_ins_q[9:7];
  assign id_c   = decode(ifid_ins_q);
  assign id_imm = {{(DATA_W-7){ifid_ins_q[6]}}, ifid_ins_q[6:0]};

  // Register read with write-through of the value WB commits on this edge.
  always_comb begin
    id_a = rf_q[id_rs];
    id_b = rf_q[id_rt];
    if (memwb_rw_q && memwb_dest_q == id_rs) id_a = memwb_data_q;
    if (memwb_rw_q && memwb_dest_q == id_rt) id_b = memwb_data_q;
    if (id_rs == 3'd0) id_a = '0;
    if (id_rt == 3'd0) id_b = '0;
  end

  always_comb begin
    id_rd_rs = (ifid_ins_q[15:13] <= OP_ADDI);
    id_rd_rt = (ifid_ins_q[15:13] == OP_R) || (ifid_ins_q[15:13] == OP_SW) ||
               (ifid_ins_q[15:13] == OP_BEQ);
    if (FWD)
      stall = idex_c_q.mr && idex_c_q.rw &&
              (idex_c_q.dest == id_rs || (id_rd_rt && idex_c_q.dest == id_rt));
    else
      stall = (idex_c_q.rw && ((id_rd_rs && idex_c_q.dest == id_rs) ||
                               (id_rd_rt && idex_c_q.dest == id_rt))) ||
              (exmem_rw_q && ((id_rd_rs && exmem_dest_q == id_rs) ||
                              (id_rd_rt && exmem_dest_q == id_rt)));
  end

  // EX/MEM beats MEM/WB; a load in EX/MEM has no data yet and is never a source.
  always_comb begin
    ex_a = idex_a_q;
    ex_b = idex_b_q;
    if (FWD && exmem_rw_q && !exmem_mr_q && exmem_dest_q == idex_rs_q) ex_a = exmem_alu_q;
    else if (FWD && memwb_rw_q && memwb_dest_q == idex_rs_q)          ex_a = memwb_data_q;
    if (FWD && exmem_rw_q && !exmem_mr_q && exmem_dest_q == idex_rt_q) ex_b = exmem_alu_q;
    else if (FWD && memwb_rw_q && memwb_dest_q == idex_rt_q)          ex_b = memwb_data_q;
    ex_op2 = idex_c_q.imm ? idex_imm_q : ex_b;
    case (idex_c_q.alu)
      3'd1:    ex_res = ex_a - ex_op2;
      3'd2:    ex_res = ex_a & ex_op2;
      3'd3:    ex_res = ex_a | ex_op2;
      3'd4:    ex_res = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(ex_op2))};
      default: ex_res = ex_a + ex_op2;
    endcase
    flush  = idex_c_q.br && (ex_a == ex_b);
    ex_tgt = idex_pc_q + DATA_W'(2) + (idex_imm_q << 1);
  end

  always_comb begin
    pc_d = pc_q + DATA_W'(2);
    if (flush)      pc_d = ex_tgt;
    else if (stall) pc_d = pc_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q         <= '0;
      ifid_ins_q   <= '0;
      ifid_pc_q    <= '0;
      idex_c_q     <= '0;
      idex_pc_q    <= '0;
      idex_a_q     <= '0;
      idex_b_q     <= '0;
      idex_imm_q   <= '0;
      idex_rs_q    <= '0;
      idex_rt_q    <= '0;
      exmem_rw_q   <= 1'b0;
      exmem_mr_q   <= 1'b0;
      exmem_mw_q   <= 1'b0;
      exmem_dest_q <= '0;
      exmem_alu_q  <= '0;
      exmem_sd_q   <= '0;
      memwb_rw_q   <= 1'b0;
      memwb_dest_q <= '0;
      memwb_data_q <= '0;
      vld_pipe_q   <= '0;
      instret_q    <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (flush) begin
        ifid_ins_q <= '0;
        ifid_pc_q  <= '0;
      end else if (!stall) begin
        ifid_ins_q <= imemrdata;
        ifid_pc_q  <= pc_q;
      end
      if (flush || stall) begin
        idex_c_q <= '0;
      end else begin
        idex_c_q <= id_c;
      end
      idex_pc_q  <= ifid_pc_q;
      idex_a_q   <= id_a;
      idex_b_q   <= id_b;
      idex_imm_q <= id_imm;
      idex_rs_q  <= id_rs;
      idex_rt_q  <= id_rt;
      vld_pipe_q <= {vld_pipe_q[1:0], (ifid_ins_q != 16'h0) && !flush && !stall};

      exmem_rw_q   <= idex_c_q.rw;
      exmem_mr_q   <= idex_c_q.mr;
      exmem_mw_q   <= idex_c_q.mw;
      exmem_dest_q <= idex_c_q.dest;
      exmem_alu_q  <= ex_res;
      exmem_sd_q   <= ex_b;

      memwb_rw_q   <= exmem_rw_q;
      memwb_dest_q <= exmem_dest_q;
      memwb_data_q <= exmem_mr_q ? dmemrdata : exmem_alu_q;

      if (memwb_rw_q) rf_q[memwb_dest_q] <= memwb_data_q;
      if (vld_pipe_q[2]) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign imemaddr  = pc_q;
  assign dmemaddr  = exmem_alu_q;
  assign dmemwdata = exmem_sd_q;
  assign dmemwrite = exmem_mw_q;
  assign dmemread  = exmem_mr_q;
  assign aluresult = ex_res;
  assign instret   = instret_q;

endmodule

// File: tb/tb_pmips_core_p.sv
// Bench for pmips_core_p: three builds (16-bit forwarding, 16-bit interlock-only, 32-bit)
// run the same programs; stores are checked against an expected-store queue per build.
module tb_pmips_core_p;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;
  logic mon_en = 1'b1;
  logic [15:0] imem [64];

  typedef struct { logic [31:0] a; logic [31:0] d; } st_t;
  st_t q_m[$], q_n[$], q_w[$];
  int st_m, st_n, st_w, fl_m, fl_n, fl_w;
  int wr_m = 0;

  // 16-bit forwarding build
  logic [15:0] m_ia, m_id, m_da, m_dwd, m_drd, m_alu;
  logic        m_dw, m_dr, m_st, m_fl;
  logic [31:0] m_ir;
  logic [15:0] dm_m [128];
  // 16-bit interlock-only build
  logic [15:0] n_ia, n_id, n_da, n_dwd, n_drd, n_alu;
  logic        n_dw, n_dr, n_st, n_fl;
  logic [31:0] n_ir;
  logic [15:0] dm_n [128];
  // 32-bit build
  logic [31:0] w_ia, w_da, w_dwd, w_drd, w_alu;
  logic [15:0] w_id;
  logic        w_dw, w_dr, w_st, w_fl;
  logic [31:0] w_ir;
  logic [31:0] dm_w [128];

  pmips_core_p #(.DATA_W(16), .FORWARD_EN(1), .CNT_W(32)) u_dut (
    .clock(clock), .reset(reset), .imemaddr(m_ia), .imemrdata(m_id), .dmemaddr(m_da),
    .dmemwdata(m_dwd), .dmemwrite(m_dw), .dmemread(m_dr), .dmemrdata(m_drd),
    .aluresult(m_alu), .stall(m_st), .flush(m_fl), .instret(m_ir));
  pmips_core_p #(.DATA_W(16), .FORWARD_EN(0), .CNT_W(32)) u_nf (
    .clock(clock), .reset(reset), .imemaddr(n_ia), .imemrdata(n_id), .dmemaddr(n_da),
    .dmemwdata(n_dwd), .dmemwrite(n_dw), .dmemread(n_dr), .dmemrdata(n_drd),
    .aluresult(n_alu), .stall(n_st), .flush(n_fl), .instret(n_ir));
  pmips_core_p #(.DATA_W(32), .FORWARD_EN(1), .CNT_W(32)) u_w32 (
    .clock(clock), .reset(reset), .imemaddr(w_ia), .imemrdata(w_id), .dmemaddr(w_da),
    .dmemwdata(w_dwd), .dmemwrite(w_dw), .dmemread(w_dr), .dmemrdata(w_drd),
    .aluresult(w_alu), .stall(w_st), .flush(w_fl), .instret(w_ir));

  assign m_id  = (m_ia[15:7] == 0) ? imem[m_ia[6:1]] : 16'h0;
  assign n_id  = (n_ia[15:7] == 0) ? imem[n_ia[6:1]] : 16'h0;
  assign w_id  = (w_ia[31:7] == 0) ? imem[w_ia[6:1]] : 16'h0;
  assign m_drd = dm_m[m_da[7:1]];
  assign n_drd = dm_n[n_da[7:1]];
  assign w_drd = dm_w[w_da[7:1]];

  // Data memories: word 0 holds 0x00A5 after every reset.
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 128; i++) begin dm_m[i] <= 16'h0; dm_n[i] <= 16'h0; dm_w[i] <= 32'h0; end
      dm_m[0] <= 16'h00A5; dm_n[0] <= 16'h00A5; dm_w[0] <= 32'h000000A5;
    end else begin
      if (m_dw) begin dm_m[m_da[7:1]] <= m_dwd; wr_m <= wr_m + 1; end
      if (n_dw) dm_n[n_da[7:1]] <= n_dwd;
      if (w_dw) dm_w[w_da[7:1]] <= w_dwd;
    end
  end

  task automatic exp_st(input logic [31:0] a, input logic [31:0] d16, input logic [31:0] d32);
    q_m.push_back('{a, d16});
    q_n.push_back('{a, d16});
    q_w.push_back('{a, d32});
  endtask

  // Advance one cycle, sampling on the falling edge; pops the scoreboard on every store.
  task automatic cyc();
    st_t e;
    @(negedge clock);
    if (reset) begin
      st_m += int'(m_st); st_n += int'(n_st); st_w += int'(w_st);
      fl_m += int'(m_fl); fl_n += int'(n_fl); fl_w += int'(w_fl);
      if (mon_en && m_dw) begin
        n_chk++;
        if (q_m.size() == 0) begin n_fail++; $display("FAIL store_fwd16: unexpected addr %h data %h", m_da, m_dwd); end
        else begin
          e = q_m.pop_front();
          if ({16'h0, m_da} !== e.a || {16'h0, m_dwd} !== e.d) begin
            n_fail++; $display("FAIL store_fwd16: got %h/%h expected %h/%h", m_da, m_dwd, e.a, e.d);
          end
        end
      end
      if (mon_en && n_dw) begin
        n_chk++;
        if (q_n.size() == 0) begin n_fail++; $display("FAIL store_nofwd16: unexpected addr %h data %h", n_da, n_dwd); end
        else begin
          e = q_n.pop_front();
          if ({16'h0, n_da} !== e.a || {16'h0, n_dwd} !== e.d) begin
            n_fail++; $display("FAIL store_nofwd16: got %h/%h expected %h/%h", n_da, n_dwd, e.a, e.d);
          end
        end
      end
      if (mon_en && w_dw) begin
        n_chk++;
        if (q_w.size() == 0) begin n_fail++; $display("FAIL store_w32: unexpected addr %h data %h", w_da, w_dwd); end
        else begin
          e = q_w.pop_front();
          if (w_da !== e.a || w_dwd !== e.d) begin
            n_fail++; $display("FAIL store_w32: got %h/%h expected %h/%h", w_da, w_dwd, e.a, e.d);
          end
        end
      end
    end
  endtask

  task automatic start(input logic [15:0] p [8]);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = 16'h0;
    for (int i = 0; i < 8; i++) imem[i] = p[i];
    repeat (2) @(negedge clock);
    st_m = 0; st_n = 0; st_w = 0; fl_m = 0; fl_n = 0; fl_w = 0;
    reset = 1'b1;
  endtask

  task automatic finish_prog(input string nm, input int ir_exp, input int stm, input int stn, input int stw);
    repeat (24) cyc();
    n_chk++;
    if (m_ir !== ir_exp || n_ir !== ir_exp || w_ir !== ir_exp) begin
      n_fail++; $display("FAIL %s_instret: got %0d/%0d/%0d expected %0d", nm, m_ir, n_ir, w_ir, ir_exp);
    end
    n_chk++;
    if (st_m != stm || st_n != stn || st_w != stw) begin
      n_fail++; $display("FAIL %s_stalls: got %0d/%0d/%0d expected %0d/%0d/%0d", nm, st_m, st_n, st_w, stm, stn, stw);
    end
    n_chk++;
    if (q_m.size() + q_n.size() + q_w.size() != 0) begin
      n_fail++; $display("FAIL %s_missing_stores: %0d/%0d/%0d still expected", nm, q_m.size(), q_n.size(), q_w.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_chk++;
    if (m_ia !== 16'h0 || m_dw !== 1'b0 || m_dr !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: pc %h dwr %b drd %b expected 0 0 0", m_ia, m_dw, m_dr);
    end
    n_chk++;
    if (m_st !== 1'b0 || m_fl !== 1'b0 || m_ir !== 32'h0) begin
      n_fail++; $display("FAIL reset_status: stall %b flush %b instret %0d expected 0 0 0", m_st, m_fl, m_ir);
    end
  endtask

  task automatic test_basic();
    logic [15:0] p [8] = '{16'h8085, 16'h8107, 16'h0530, 16'h4180, 16'h4082, 16'h4104, 16'h0, 16'h0};
    exp_st(0, 12, 12); exp_st(2, 5, 5); exp_st(4, 7, 7);
    start(p);
    cyc();
    n_chk++;
    if (m_ia !== 16'h2) begin n_fail++; $display("FAIL basic_pc1: got %h expected 0002", m_ia); end
    repeat (3) cyc();
    n_chk++;
    if (m_alu !== 16'd12) begin n_fail++; $display("FAIL basic_add_fwd: got %h expected 000c", m_alu); end
    repeat (3) cyc();
    n_chk++;
    if (m_ir !== 32'd3) begin n_fail++; $display("FAIL basic_instret7: got %0d expected 3", m_ir); end
    finish_prog("basic", 6, 0, 4, 0);
  endtask

  task automatic test_load_use();
    logic [15:0] p [8] = '{16'h2200, 16'h1250, 16'h4286, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    exp_st(6, 16'h014A, 32'h014A);
    start(p);
    repeat (2) cyc();
    n_chk++;
    if (m_st !== 1'b1) begin n_fail++; $display("FAIL lu_stall_on: got %b expected 1", m_st); end
    cyc();
    n_chk++;
    if (m_st !== 1'b0 || m_dr !== 1'b1) begin
      n_fail++; $display("FAIL lu_stall_off: stall %b dmemread %b expected 0 1", m_st, m_dr);
    end
    cyc();
    n_chk++;
    if (m_alu !== 16'h014A) begin n_fail++; $display("FAIL lu_load_fwd: got %h expected 014a", m_alu); end
    finish_prog("loaduse", 3, 1, 4, 1);
  endtask

  task automatic test_branch();
    logic [15:0] p [8] = '{16'h8081, 16'h0, 16'h6002, 16'h8089, 16'h8109, 16'h4088, 16'h410A, 16'h0};
    exp_st(8, 1, 1); exp_st(10, 0, 0);
    start(p);
    repeat (4) cyc();
    n_chk++;
    if (m_fl !== 1'b1) begin n_fail++; $display("FAIL br_flush: got %b expected 1", m_fl); end
    cyc();
    n_chk++;
    if (m_ia !== 16'd10 || m_fl !== 1'b0) begin
      n_fail++; $display("FAIL br_target: pc %h flush %b expected 000a 0", m_ia, m_fl);
    end
    finish_prog("branch", 4, 0, 0, 0);
    n_chk++;
    if (fl_m != 1 || fl_n != 1 || fl_w != 1) begin
      n_fail++; $display("FAIL br_flush_count: got %0d/%0d/%0d expected 1/1/1", fl_m, fl_n, fl_w);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] p [8] = '{16'h8083, 16'h8104, 16'h8185, 16'h0, 16'h0, 16'h408C, 16'h0, 16'h0};
    int w0;
    mon_en = 1'b0;
    start(p);
    w0 = wr_m;
    repeat (8) cyc();
    n_chk++;
    if (m_dw !== 1'b1 || m_ir !== 32'd3) begin
      n_fail++; $display("FAIL rst_pre: dmemwrite %b instret %0d expected 1 3", m_dw, m_ir);
    end
    #1 reset = 1'b0;
    #1;
    n_chk++;
    if (m_dw !== 1'b0 || m_ia !== 16'h0 || m_ir !== 32'h0) begin
      n_fail++; $display("FAIL rst_async: dmemwrite %b pc %h instret %0d expected 0 0000 0", m_dw, m_ia, m_ir);
    end
    repeat (3) @(negedge clock);
    n_chk++;
    if (wr_m != w0) begin n_fail++; $display("FAIL rst_no_store: writes %0d expected %0d", wr_m - w0, 0); end
    reset = 1'b1;
    cyc();
    n_chk++;
    if (m_ia !== 16'h2 || m_ir !== 32'h0) begin
      n_fail++; $display("FAIL rst_restart: pc %h instret %0d expected 0002 0", m_ia, m_ir);
    end
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_wide();
    logic [15:0] p [8] = '{16'h80FF, 16'h8501, 16'h0434, 16'h4090, 16'h4112, 16'h4194, 16'h0, 16'h0};
    exp_st(16, 16'hFFFF, 32'hFFFFFFFF); exp_st(18, 0, 0); exp_st(20, 1, 1);
    start(p);
    repeat (2) cyc();
    n_chk++;
    if (w_alu !== 32'hFFFFFFFF || m_alu !== 16'hFFFF) begin
      n_fail++; $display("FAIL wide_sext: got %h/%h expected ffffffff/ffff", w_alu, m_alu);
    end
    finish_prog("wide", 6, 0, 2, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_use();
    test_branch();
    test_reset_mid();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pmips_core_p.md
Name: pmips_core_p

Overview:
- Parametrised 5-stage (IF/ID/EX/MEM/WB) pipelined 16-bit-instruction MIPS-subset core.
- Successor of the fixed 16-bit PMIPS pipeline. Datapath width is parametric.
- Adds EX-stage operand forwarding, a load-use interlock, branch resolution in EX with flush, and a retired-instruction counter.
- Sits between the instruction ROM and data RAM in the board top; memories are external.

Parameters:
- DATA_W, 16: datapath, register, PC and memory-address width; must be >= 16.
- FORWARD_EN, 1: 1 enables EX/MEM and MEM/WB forwarding. 0 stalls in ID on any RAW hazard against ID/EX or EX/MEM.
- CNT_W, 32: width of retired-instruction counter.

Ports:
- clock, input, 1: sole clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-low (0 = reset asserted).
- imemaddr, output, DATA_W: PC; instruction fetch address.
- imemrdata, input, 16: instruction word; combinational function of imemaddr within the same cycle.
- dmemaddr, output, DATA_W: EX/MEM ALU result.
- dmemwdata, output, DATA_W: EX/MEM store data.
- dmemwrite, output, 1: store enable (MEM stage).
- dmemread, output, 1: load enable (MEM stage).
- dmemrdata, input, DATA_W: load data; combinational from dmemaddr.
- aluresult, output, DATA_W: EX-stage ALU output (debug).
- stall, output, 1: interlock active this cycle.
- flush, output, 1: taken branch in EX this cycle.
- instret, output, CNT_W: count of non-bubble instructions completing WB.

Behaviour:
- Reset (reset=0, async):
  - PC=0; all pipeline registers cleared to bubbles (instr=0, all control=0); r0..r7=0; instret=0.
  - Outputs while in reset: dmemwrite=0, dmemread=0, stall=0, flush=0.
  - Reset mid-operation discards all in-flight instructions. Fetch restarts at address 0 on the first rising edge after release.
- ISA:
  - Fields: op=[15:13], rs=[12:10], rt=[9:7], rd=[6:4], funct=[3:0], imm=sext([6:0]) to DATA_W.
  - 000 R-type rd<=rs op rt. funct: 0 add, 1 sub, 2 and, 3 or, 4 slt (signed, result 0/1); other funct = nop.
  - 001 lw: rt<=mem[rs+imm].
  - 010 sw: mem[rs+imm]<=rt.
  - 011 beq: if rs==rt, PC<=PC_b+2+(imm<<1), where PC_b is the branch's own address.
  - 100 addi: rt<=rs+imm.
  - 101-111: nop.
  - Instruction 16'h0000 is nop and is not counted as retired.
  - r0 always reads 0; writes to r0 are discarded.
  - Arithmetic wraps modulo 2^DATA_W.
- Fetch:
  - PC+2 each cycle unless stall or flush.
  - Instructions are 16-bit; the PC increments by 2 regardless of DATA_W.
- Register file:
  - Written on rising edge from WB.
  - ID reads see a same-cycle WB write (internal write-through bypass).
- Forwarding (FORWARD_EN=1), per EX operand:
  - Priority 1: EX/MEM (RegWrite, not load, dest!=0, dest==src).
  - Priority 2: MEM/WB (RegWrite, dest!=0, dest==src; load data or ALU result).
  - Otherwise the ID/EX register value.
  - Store data (rt) is forwarded by the same rules.
- Load-use interlock:
  - Condition: ID/EX is lw, its rt!=0, and rt equals the ID instruction's rs, or its rt when that instruction reads rt (R-type, sw, beq).
  - Response: stall=1 for exactly 1 cycle; PC and IF/ID hold; ID/EX loads a bubble.
- FORWARD_EN=0:
  - Stall while ID/EX or EX/MEM has a nonzero dest matching any source read by the ID instruction.
  - MEM/WB hazards are covered by the register-file bypass.
- Branch:
  - Compare uses forwarded operands in EX.
  - If taken: flush=1; on that edge PC<=target, and IF/ID and ID/EX become bubbles. Penalty is 2 cycles.
  - Not taken: no penalty.
  - Flush has priority over stall when both are asserted in the same cycle.
- Memory outputs:
  - Load result reaches MEM/WB one edge after the MEM stage.
  - Latency fetch->WB is 4 edges when there is no stall.
- instret:
  - Increments on each edge where MEM/WB holds a non-bubble instruction.
  - Wraps at 2^CNT_W.

Test Plan:
- Reset release, program "addi r1,r0,5; addi r2,r0,7; add r3,r1,r2" (FORWARD_EN=1) -> no stall cycles; r3=12 written on the 6th rising edge after release; instret=3.
- "lw r4,0(r0)" with mem[0]=16'h00A5, followed by "add r5,r4,r4" -> exactly one stall=1 cycle; r5=16'h014A.
- "beq r0,r0,+2" at PC=4 -> flush=1 for one cycle; next fetch address 10; the two younger instructions never write registers; they are not counted in instret.
- FORWARD_EN=0, same program as the first scenario -> stall held 2 cycles before the add; r3=12; final register state identical.
- Assert reset=0 mid-stream with a sw in EX -> dmemwrite=0 immediately (async); PC=0; instret=0; no store reaches memory.
- DATA_W=32: "addi r1,r0,-1; addi r2,r1,1" -> r1=32'hFFFFFFFF, r2=0; "slt r3,r1,r0" -> r3=1.
